comparator_stream: RTL



---
 rtl/comparator_pkg.sv | 23 ++
 rtl/cmp_core.sv | 42 ++++
 rtl/comparator_stream.sv | 91 +++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// -----------------------------------------------------------------------------
// comparator_pkg
// Shared definitions for the comparator_stream block:
//   - 2-bit result code carried from the compare core to the result register
//   - run-tracking FSM state encodings
// -----------------------------------------------------------------------------
package comparator_pkg;

    typedef logic [1:0] cmp_code_t;

    // Result codes. CMP_NONE is only ever held out of reset, so all three
    // decoded flags read 0 until the first accept.
    localparam cmp_code_t CMP_NONE = 2'b00;
    localparam cmp_code_t CMP_LT   = 2'b01;
    localparam cmp_code_t CMP_EQ   = 2'b10;
    localparam cmp_code_t CMP_GT   = 2'b11;

    // Run-tracking FSM states.
    localparam logic [1:0] ST_EMPTY  = 2'b00;
    localparam logic [1:0] ST_TRACK  = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

endpackage

// File: rtl/cmp_core.sv
// -----------------------------------------------------------------------------
// cmp_core
// Combinational magnitude compare of one operand pair.
// Ports:
//   in0, in1     [WIDTH-1:0] operands A and B
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   code         result code (CMP_LT / CMP_EQ / CMP_GT), never CMP_NONE
// -----------------------------------------------------------------------------
module cmp_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             signed_mode,
    output cmp_code_t        code
);

    logic [WIDTH-1:0] sign_flip;
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;

    // Inverting the MSB maps two's-complement order onto unsigned order, so a
    // single unsigned comparator serves both modes.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = signed_mode;
        a_key                = in0 ^ sign_flip;
        b_key                = in1 ^ sign_flip;
        if (a_key == b_key) begin
            code = CMP_EQ;
        end else if (a_key > b_key) begin
            code = CMP_GT;
        end else begin
            code = CMP_LT;
        end
    end

endmodule

// File: rtl/comparator_stream.sv
// -----------------------------------------------------------------------------
// comparator_stream
// Registered, valid/ready handshaked comparator with run-length debounce.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (in0, in1, signed_mode sampled)
//   out_valid/out_ready result handshake
//   EQ, GTR, LR         one-hot result flags (in0 ==, >, < in1)
//   stable              run_len has reached STABLE_CNT
//   run_len             consecutive identical results incl. current, saturating
// -----------------------------------------------------------------------------
module comparator_stream
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STABLE_CNT = 4,
    parameter int RUN_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             EQ,
    output logic             GTR,
    output logic             LR,
    output logic             stable,
    output logic [RUN_W-1:0] run_len
);

    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [RUN_W-1:0] STABLE_TH = RUN_W'(STABLE_CNT);

    cmp_code_t        cur_code;
    cmp_code_t        res_code;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [RUN_W-1:0] run_next;
    logic             same;
    logic             accept;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .in0         (in0),
        .in1         (in1),
        .signed_mode (signed_mode),
        .code        (cur_code)
    );

    assign in_ready = !rst && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // res_code survives consumption of the result, so it doubles as the
    // "previous result" for run tracking.
    always_comb begin
        same     = (state != ST_EMPTY) && (cur_code == res_code);
        run_next = RUN_W'(1);
        if (same) begin
            run_next = (run_len == RUN_MAX) ? run_len : run_len + 1'b1;
        end
        state_next = (run_next >= STABLE_TH) ? ST_LOCKED : ST_TRACK;
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            res_code  <= CMP_NONE;
            run_len   <= '0;
            state     <= ST_EMPTY;
        end else if (accept) begin
            out_valid <= 1'b1;
            res_code  <= cur_code;
            run_len   <= run_next;
            state     <= state_next;
        end else if (out_ready) begin
            // Result consumed with nothing new: flags and run_len hold.
            out_valid <= 1'b0;
        end
    end

    assign EQ     = (res_code == CMP_EQ);
    assign GTR    = (res_code == CMP_GT);
    assign LR     = (res_code == CMP_LT);
    assign stable = (state == ST_LOCKED);

endmodule
